// File: rtl/alu_pkg.sv
// Shared types for the ALU command driver: opcodes, driver FSM states, command record.
package alu_pkg;

  localparam int ALU_W = 64;
  localparam int TAG_W = 8;

  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b1000,
    AND  = 4'b0111,
    OR   = 4'b0110,
    XOR  = 4'b0100,
    SLL  = 4'b0001,
    SRL  = 4'b0101,
    SRA  = 4'b1101,
    SLT  = 4'b0010,
    SLTU = 4'b0011
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } drv_state_t;

  typedef struct packed {
    alu_op_t            op;
    logic [ALU_W-1:0]   a;
    logic [ALU_W-1:0]   b;
    logic [TAG_W-1:0]   tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Purpose: synchronous FIFO of command records, DEPTH entries, wrap-bit pointers.
// Latency: pushed entry visible at the head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; no push-through bypass.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output T     pop_dat,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Purpose: queue ALU commands, drive them SETTLE cycles, return tagged results; ALU_DRV_SELFCHECK_EN adds a sticky mismatch checker.
// Latency: accept at edge t on an idle, empty driver -> rsp_valid after edge t+1+SETTLE; one result per SETTLE+1 cycles.
// Backpressure: cmd_ready = !full; rsp_* held while rsp_valid && !rsp_ready, next command launches on the accepting edge.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [7:0]       rsp_tag,
  output logic             busy
`ifdef ALU_DRV_SELFCHECK_EN
  ,
  output logic             mismatch
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [7:0]       tag;
  } cmd_t;

  drv_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    tag_cnt;
  logic [7:0]    cur_tag;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          capture;
  cmd_t          wr_cmd;
  cmd_t          head;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign wr_cmd    = {cmd_op, cmd_a, cmd_b, tag_cnt};
  assign busy      = !fifo_empty || (state != IDLE);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (wr_cmd),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // Chain straight into the next command so back-to-back ops lose no cycle.
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = DRIVE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      tag_cnt    <= '0;
      cur_tag    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      state <= state_nxt;
      if (push) tag_cnt <= tag_cnt + 8'd1;
      if (pop) begin
        alu_a   <= head.a;
        alu_b   <= head.b;
        alu_op  <= head.op;
        cur_tag <= head.tag;
        cnt     <= CW'(SETTLE - 1);
      end else if (state == DRIVE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_out;
        rsp_zero   <= alu_zero;
        rsp_tag    <= cur_tag;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_DRV_SELFCHECK_EN
  logic [WIDTH-1:0] ref_res;
  logic             ref_chk;

  always_comb begin
    ref_res = '0;
    ref_chk = 1'b1;
    case (alu_op)
      ADD:     ref_res = alu_a + alu_b;
      SUB:     ref_res = alu_a - alu_b;
      AND:     ref_res = alu_a & alu_b;
      OR:      ref_res = alu_a | alu_b;
      default: ref_chk = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
    end else if (capture && ref_chk &&
                 ((alu_out != ref_res) || (alu_zero != (ref_res == '0)))) begin
      mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: vector table plus hand-written backpressure, reset and tag-wrap sequences.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [63:0] cmd_a = '0;
  logic [63:0] cmd_b = '0;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_out;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic        rsp_zero;
  logic [7:0]  rsp_tag;
  logic        busy;
  logic        bad_and = 1'b0;
`ifdef ALU_DRV_SELFCHECK_EN
  logic        mismatch;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_cmd_driver #(.WIDTH(64), .DEPTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .busy(busy)
`ifdef ALU_DRV_SELFCHECK_EN
    , .mismatch(mismatch)
`endif
  );

  // Behavioural ALU; undefined opcodes echo the opcode so pass-through is visible.
  always_comb begin
    case (alu_op)
      ADD:     alu_out = alu_a + alu_b;
      SUB:     alu_out = alu_a - alu_b;
      AND:     alu_out = alu_a & alu_b;
      OR:      alu_out = alu_a | alu_b;
      XOR:     alu_out = alu_a ^ alu_b;
      SLL:     alu_out = alu_a << alu_b[5:0];
      SRL:     alu_out = alu_a >> alu_b[5:0];
      SRA:     alu_out = $signed(alu_a) >>> alu_b[5:0];
      SLT:     alu_out = {63'd0, $signed(alu_a) < $signed(alu_b)};
      SLTU:    alu_out = {63'd0, alu_a < alu_b};
      default: alu_out = {60'd0, alu_op};
    endcase
    if (bad_and && alu_op == AND && alu_a == 64'd1 && alu_b == 64'd2) alu_out = 64'd1;
    alu_zero = (alu_out == 64'd0);
  end

  typedef struct packed {
    logic [63:0] res;
    logic        z;
    logic [7:0]  tag;
  } rsp_t;

  rsp_t got_q[$];

  // Inputs change 2ns after posedge, so a negedge sample sees the handshake of the coming edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) got_q.push_back({rsp_result, rsp_zero, rsp_tag});
  end

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        z;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic acc;
    int   guard;
    acc = 1'b0;
    guard = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #2;
      guard++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      step(1);
      c++;
    end
    chk("rsp_count", 64'(got_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   bad;
    rsp_t r;

    tbl[0]  = '{SUB,   64'd2,    64'd2,    64'd0,                   1'b1};
    tbl[1]  = '{SUB,   64'd4,    64'd5,    64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[2]  = '{SUB,   64'd5,    64'd4,    64'd1,                   1'b0};
    tbl[3]  = '{AND,   64'hF0,   64'h3C,   64'h30,                  1'b0};
    tbl[4]  = '{OR,    64'hF0,   64'h0F,   64'hFF,                  1'b0};
    tbl[5]  = '{XOR,   64'hFF,   64'h0F,   64'hF0,                  1'b0};
    tbl[6]  = '{SLL,   64'd1,    64'd4,    64'h10,                  1'b0};
    tbl[7]  = '{SRA,   64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0};
    tbl[8]  = '{SLT,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1,       1'b0};
    tbl[9]  = '{SLTU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,       1'b1};
    tbl[10] = '{4'hF,  64'd7,    64'd9,    64'hF,                   1'b0};
    tbl[11] = '{AND,   64'd1,    64'd2,    64'd0,                   1'b1};

    // Reset values
    step(2);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_zero", 64'(rsp_zero), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    rst_n = 1'b1;
    step(1);

    // First-command latency: accept at edge t, rsp_valid after edge t+2
    rsp_ready = 1'b1;
    send(ADD, 64'd1, 64'd2);
    @(negedge clk);
    chk("lat_rsp_valid_t0", 64'(rsp_valid), 64'd0);
    chk("lat_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("lat_rsp_valid_t1", 64'(rsp_valid), 64'd0);
    chk("lat_alu_a", alu_a, 64'd1);
    @(negedge clk);
    chk("lat_rsp_valid_t2", 64'(rsp_valid), 64'd1);
    chk("lat_result", rsp_result, 64'd3);
    chk("lat_zero", 64'(rsp_zero), 64'd0);
    chk("lat_tag", 64'(rsp_tag), 64'd0);
    step(2);
    got_q.delete();

    // Vector table, back-to-back with tags 1..12
    for (int i = 0; i < 12; i++) send(tbl[i].op, tbl[i].a, tbl[i].b);
    wait_rsp(12, 200);
    for (int i = 0; i < 12; i++) begin
      if (i < got_q.size()) begin
        r = got_q[i];
        chk($sformatf("vec%0d_result", i), r.res, tbl[i].res);
        chk($sformatf("vec%0d_zero", i), 64'(r.z), 64'(tbl[i].z));
        chk($sformatf("vec%0d_tag", i), 64'(r.tag), 64'(i + 1));
      end
    end
    step(2);
    got_q.delete();

    // Backpressure: one in flight plus four queued fills the driver
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(ADD, 64'(i), 64'd100);
    @(negedge clk);
    chk("bp_cmd_ready_full", 64'(cmd_ready), 64'd0);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_rsp_result", rsp_result, 64'd100);
    cmd_valid = 1'b1;
    cmd_op = ADD;
    cmd_a = 64'd999;
    cmd_b = 64'd0;
    step(5);
    @(negedge clk);
    chk("bp_still_full", 64'(cmd_ready), 64'd0);
    chk("bp_result_hold", rsp_result, 64'd100);
    chk("bp_tag_hold", 64'(rsp_tag), 64'd13);
    chk("bp_alu_b_hold", alu_b, 64'd100);
    cmd_valid = 1'b0;
    step(1);
    rsp_ready = 1'b1;
    wait_rsp(5, 100);
    step(10);
    chk("bp_no_dup", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) begin
        r = got_q[i];
        chk($sformatf("bp%0d_result", i), r.res, 64'(100 + i));
        chk($sformatf("bp%0d_tag", i), 64'(r.tag), 64'(13 + i));
      end
    end
    got_q.delete();

    // Reset while in DRIVE with three commands queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(ADD, 64'(10 + i), 64'd0);
    rsp_ready = 1'b1;
    send(ADD, 64'd20, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_alu_a", alu_a, 64'd0);
    chk("mid_rst_rsp_result", rsp_result, 64'd0);
    chk("mid_rst_rsp_tag", 64'(rsp_tag), 64'd0);
    got_q.delete();
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("post_rst_no_rsp", 64'(got_q.size()), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    send(ADD, 64'd7, 64'd8);
    wait_rsp(1, 20);
    if (got_q.size() > 0) begin
      r = got_q[0];
      chk("post_rst_result", r.res, 64'd15);
      chk("post_rst_tag", 64'(r.tag), 64'd0);
    end

    // 257 commands: tag wraps 255 -> 0
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 257; i++) send(ADD, 64'(i), 64'd1);
    wait_rsp(257, 100);
    bad = 0;
    for (int i = 0; i < 257; i++) begin
      if (i < got_q.size()) begin
        r = got_q[i];
        if (r.tag != 8'(i) || r.res != 64'(i + 1)) bad++;
      end
    end
    chk("wrap_seq_errors", 64'(bad), 64'd0);
    if (got_q.size() == 257) begin
      r = got_q[255];
      chk("wrap_tag255", 64'(r.tag), 64'd255);
      r = got_q[256];
      chk("wrap_tag256", 64'(r.tag), 64'd0);
      chk("wrap_result256", r.res, 64'd257);
    end

`ifdef ALU_DRV_SELFCHECK_EN
    do_reset();
    chk("sc_rst_mismatch", 64'(mismatch), 64'd0);
    rsp_ready = 1'b1;
    send(AND, 64'd1, 64'd2);
    send(SUB, 64'd3, 64'd3);
    wait_rsp(2, 20);
    chk("sc_good_alu", 64'(mismatch), 64'd0);
    bad_and = 1'b1;
    send(AND, 64'd1, 64'd2);
    wait_rsp(3, 20);
    chk("sc_bad_and", 64'(mismatch), 64'd1);
    bad_and = 1'b0;
    send(ADD, 64'd1, 64'd1);
    wait_rsp(4, 20);
    chk("sc_sticky", 64'(mismatch), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
